// File: rtl/arith_engine.sv
// arith_engine: add/sub/mul in one cycle, restoring divide over DATA_W
// cycles, with a valid/ready request side and a valid/ready result side.
module arith_engine #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_value_a,
   input  logic [DATA_W-1:0] i_value_b,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_value_lo,
   output logic [DATA_W-1:0] o_value_hi,
   output logic              o_div_zero
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0]   div_b;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   rem;
   logic [CW-1:0]       cnt;
   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     dif;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W:0]     shft;
   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   quo_nxt;
   logic [DATA_W-1:0]   rem_nxt;
   logic                accept;
   logic                last;
   logic                b_zero;

   // Ready is withheld while reset is held so nothing is accepted then
   assign o_ready = (state == IDLE) & ~i_reset;
   assign o_valid = (state == DONE);
   assign accept  = i_valid & o_ready;
   assign last    = (cnt == CW'(DATA_W - 1));
   assign b_zero  = (i_value_b == '0);

   // Single-cycle results and one restoring divide step
   always_comb begin
      sum   = {1'b0, i_value_a} + {1'b0, i_value_b};
      dif   = {1'b0, i_value_a} - {1'b0, i_value_b};
      prod  = {{DATA_W{1'b0}}, i_value_a} * {{DATA_W{1'b0}}, i_value_b};
      shft  = {rem, quo[DATA_W-1]};
      trial = shft - {1'b0, div_b};
      if (trial[DATA_W]) begin
         rem_nxt = shft[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b0};
      end else begin
         rem_nxt = trial[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b1};
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (i_op == 2'b11 && !b_zero) state_nxt = DIV;
               else                          state_nxt = DONE;
            end
         end
         DIV:  if (last) state_nxt = DONE;
         DONE: if (i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result registers and divider iteration
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_value_lo <= '0;
         o_value_hi <= '0;
         o_div_zero <= 1'b0;
         div_b      <= '0;
         quo        <= '0;
         rem        <= '0;
         cnt        <= '0;
      end else if (accept) begin
         o_div_zero <= 1'b0;
         unique case (i_op)
            2'b00: begin
               o_value_lo <= sum[DATA_W-1:0];
               o_value_hi <= {{(DATA_W-1){1'b0}}, sum[DATA_W]};
            end
            2'b01: begin
               o_value_lo <= dif[DATA_W-1:0];
               o_value_hi <= {{(DATA_W-1){1'b0}}, dif[DATA_W]};
            end
            2'b10: begin
               o_value_lo <= prod[DATA_W-1:0];
               o_value_hi <= prod[2*DATA_W-1:DATA_W];
            end
            default: begin
               if (b_zero) begin
                  o_value_lo <= '1;
                  o_value_hi <= i_value_a;
                  o_div_zero <= 1'b1;
               end else begin
                  o_value_lo <= '0;
                  o_value_hi <= '0;
                  div_b      <= i_value_b;
                  quo        <= i_value_a;
                  rem        <= '0;
                  cnt        <= '0;
               end
            end
         endcase
      end else if (state == DIV) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt + CW'(1);
         if (last) begin
            o_value_lo <= quo_nxt;
            o_value_hi <= rem_nxt;
         end
      end
   end

endmodule

// File: tb/tb_arith_engine.sv
// tb_arith_engine: directed and random requests against arith_engine
// with a scoreboard of expected results and latencies.
module tb_arith_engine;

   localparam int W = 8;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_valid;
   logic         o_ready;
   logic [1:0]   i_op;
   logic [W-1:0] i_value_a;
   logic [W-1:0] i_value_b;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_value_lo;
   logic [W-1:0] o_value_hi;
   logic         o_div_zero;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   arith_engine #(.DATA_W(W)) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_op(i_op),
      .i_value_a(i_value_a),
      .i_value_b(i_value_b),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_value_lo(o_value_lo),
      .o_value_hi(o_value_hi),
      .o_div_zero(o_div_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op,
                                  input int a, input int b);
      exp_t e;
      int r;
      e.dz  = 1'b0;
      e.lat = 1;
      case (op)
         2'd0: begin
            r = a + b;
            e.lo = W'(r % 256);
            e.hi = (r > 255) ? 8'd1 : 8'd0;
         end
         2'd1: begin
            r = a - b + 256;
            e.lo = W'(r % 256);
            e.hi = (a < b) ? 8'd1 : 8'd0;
         end
         2'd2: begin
            r = a * b;
            e.lo = W'(r % 256);
            e.hi = W'(r / 256);
         end
         default: begin
            if (b == 0) begin
               e.lo = 8'hFF;
               e.hi = W'(a);
               e.dz = 1'b1;
            end else begin
               e.lo  = W'(a / b);
               e.hi  = W'(a % b);
               e.lat = W + 1;
            end
         end
      endcase
      return e;
   endfunction

   // Drive one request, wait for its result, compare, then release it
   task automatic run_req(input string tag, input logic [1:0] op,
                          input int a, input int b, input bit rdy_early);
      exp_t e;
      int k;
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_ready && n < 50) begin
         n++;
         @(negedge i_clk);
      end
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
      i_op      = op;
      i_value_a = W'(a);
      i_value_b = W'(b);
      i_valid   = 1'b1;
      sb.push_back(model(op, a, b));
      @(posedge i_clk);
      #1;
      i_valid   = 1'b0;
      i_value_a = ~i_value_a;
      i_value_b = ~i_value_b;
      i_op      = ~op;
      if (rdy_early) i_ready = 1'b1;
      k = 1;
      @(negedge i_clk);
      while (!o_valid && k < 40) begin
         k++;
         @(negedge i_clk);
      end
      e = sb.pop_front();
      check({tag, "_lat"}, 32'(k), 32'(e.lat));
      check({tag, "_lo"}, 32'(o_value_lo), 32'(e.lo));
      check({tag, "_hi"}, 32'(o_value_hi), 32'(e.hi));
      check({tag, "_dz"}, 32'(o_div_zero), 32'(e.dz));
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] hlo;
      logic [W-1:0] hhi;
      i_reset   = 1'b1;
      i_valid   = 1'b0;
      i_ready   = 1'b0;
      i_op      = 2'd0;
      i_value_a = '0;
      i_value_b = '0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_lo", 32'(o_value_lo), 32'd0);
      check("rst_hi", 32'(o_value_hi), 32'd0);
      check("rst_dz", 32'(o_div_zero), 32'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      @(negedge i_clk);
      check("rst_rel_ready", 32'(o_ready), 32'd1);

      run_req("add", 2'd0, 200, 100, 1'b0);
      run_req("sub", 2'd1, 5, 7, 1'b0);
      run_req("mul", 2'd2, 255, 255, 1'b0);
      run_req("div", 2'd3, 200, 7, 1'b0);
      run_req("divz", 2'd3, 123, 0, 1'b0);
      run_req("div_rdy", 2'd3, 255, 1, 1'b1);
      run_req("div_big", 2'd3, 3, 200, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_req("rnd", 2'($urandom_range(3)), int'($urandom_range(255)),
                 int'($urandom_range(255)), 1'b0);
      end

      // Backpressure: hold result while inputs churn and i_valid rises
      @(negedge i_clk);
      i_op      = 2'd0;
      i_value_a = 8'd10;
      i_value_b = 8'd20;
      i_valid   = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      @(negedge i_clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      hlo = o_value_lo;
      hhi = o_value_hi;
      check("bp_lo", 32'(hlo), 32'd30);
      for (int i = 0; i < 5; i++) begin
         i_valid   = 1'b1;
         i_op      = 2'(i);
         i_value_a = W'(i * 37 + 1);
         i_value_b = W'(i * 11);
         @(negedge i_clk);
         check("bp_hold_v", 32'(o_valid), 32'd1);
         check("bp_hold_r", 32'(o_ready), 32'd0);
         check("bp_hold_lo", 32'(o_value_lo), 32'(hlo));
         check("bp_hold_hi", 32'(o_value_hi), 32'(hhi));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      @(negedge i_clk);
      check("bp_rel_ready", 32'(o_ready), 32'd1);
      check("bp_rel_valid", 32'(o_valid), 32'd0);
      repeat (3) begin
         @(negedge i_clk);
         check("bp_noqueue", 32'(o_valid), 32'd0);
      end

      // Reset in the middle of a divide
      i_op      = 2'd3;
      i_value_a = 8'd200;
      i_value_b = 8'd7;
      i_valid   = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(negedge i_clk);
      check("mr_ready", 32'(o_ready), 32'd0);
      check("mr_valid", 32'(o_valid), 32'd0);
      check("mr_lo", 32'(o_value_lo), 32'd0);
      check("mr_hi", 32'(o_value_hi), 32'd0);
      check("mr_dz", 32'(o_div_zero), 32'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      @(negedge i_clk);
      check("mr_rel_ready", 32'(o_ready), 32'd1);
      repeat (15) begin
         @(negedge i_clk);
         check("mr_no_valid", 32'(o_valid), 32'd0);
      end

      run_req("post_rst", 2'd3, 200, 7, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
